apu_mixer_seq: RTL and testbench

Time-multiplexed stereo mixer and master-volume scaler. It is the consumer of the NR50/NR51/NR52 control outputs: lmixer/rmixer, nlvolume/nrvolume, vin_l_ena/vin_r_ena and the channel active flags. Each 8-cycle frame of apuv_4mhz, it sums the four channel DAC codes plus VIN into left and right accumulators, then scales each sum by (volume+1) with sequential shift-add. It presents registered stereo sample words to the downstream DAC/PWM stage at 512 kHz.

---
 rtl/apu_mixer_seq.sv | 155 +++++++++++++++
 tb/tb_apu_mixer_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/apu_mixer_seq.sv
// Stereo mixer: 8-phase frame sums ch1..ch4+VIN per side, then scales by (vol+1) via shift-add.
// Latency: one sample word every 8 apuv_4mhz edges, strobed by sample_valid; free-running, no backpressure.

module apu_mixer_side #(
   parameter int SAMPLE_W = 4,
   parameter bit VIN_EN   = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [2:0]            phase_i,
   input  logic [SAMPLE_W-1:0]   ch1_i,
   input  logic [SAMPLE_W-1:0]   ch2_i,
   input  logic [SAMPLE_W-1:0]   ch3_i,
   input  logic [SAMPLE_W-1:0]   ch4_i,
   input  logic [3:0]            nactive_i,
   input  logic [3:0]            mixer_i,
   input  logic [2:0]            nvolume_i,
   input  logic                  vin_ena_i,
   input  logic [SAMPLE_W-1:0]   vin_i,
   output logic [SAMPLE_W+5:0]   out_o
);
   localparam int SUM_W = SAMPLE_W + 3;
   localparam int OUT_W = SAMPLE_W + 6;

   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [OUT_W-1:0]    prod_q, prod_d;
   logic [OUT_W-1:0]    out_q, out_d;
   logic [SAMPLE_W-1:0] term;
   logic [OUT_W-1:0]    sum_ext;
   logic [2:0]          vol;

   assign vol     = ~nvolume_i;
   assign sum_ext = {3'b000, sum_q};

   // Only the source owned by the current phase is looked at, so late register writes hit later phases only.
   always_comb begin
      term = '0;
      case (phase_i)
         3'd0: if (mixer_i[0] && !nactive_i[0]) term = ch1_i;
         3'd1: if (mixer_i[1] && !nactive_i[1]) term = ch2_i;
         3'd2: if (mixer_i[2] && !nactive_i[2]) term = ch3_i;
         3'd3: if (mixer_i[3] && !nactive_i[3]) term = ch4_i;
         3'd4: if (VIN_EN && vin_ena_i) term = vin_i;
         default: term = '0;
      endcase
   end

   always_comb begin
      sum_d  = sum_q;
      prod_d = prod_q;
      out_d  = out_q;
      case (phase_i)
         3'd0: sum_d = {3'b000, term};
         3'd1, 3'd2, 3'd3, 3'd4: sum_d = sum_q + {3'b000, term};
         3'd5: prod_d = sum_ext + (vol[0] ? sum_ext : '0);
         3'd6: prod_d = prod_q + (vol[1] ? (sum_ext << 1) : '0);
         3'd7: out_d  = prod_q + (vol[2] ? (sum_ext << 2) : '0);
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q  <= '0;
         prod_q <= '0;
         out_q  <= '0;
      end else begin
         sum_q  <= sum_d;
         prod_q <= prod_d;
         out_q  <= out_d;
      end
   end

   assign out_o = out_q;
endmodule

module apu_mixer_seq #(
   parameter int SAMPLE_W = 4,
   parameter bit VIN_EN   = 1'b1
) (
   input  logic                  apuv_4mhz,
   input  logic                  napu_reset,
   input  logic [SAMPLE_W-1:0]   ch1_out,
   input  logic [SAMPLE_W-1:0]   ch2_out,
   input  logic [SAMPLE_W-1:0]   ch3_out,
   input  logic [SAMPLE_W-1:0]   ch4_out,
   input  logic                  nch1_active,
   input  logic                  nch2_active,
   input  logic                  nch3_active,
   input  logic                  nch4_active,
   input  logic [3:0]            lmixer,
   input  logic [3:0]            rmixer,
   input  logic [2:0]            nlvolume,
   input  logic [2:0]            nrvolume,
   input  logic                  vin_l_ena,
   input  logic                  vin_r_ena,
   input  logic [SAMPLE_W-1:0]   vin_in,
   output logic [SAMPLE_W+5:0]   lout,
   output logic [SAMPLE_W+5:0]   rout,
   output logic                  sample_valid,
   output logic [2:0]            phase
);
   logic [2:0] phase_q, phase_d;
   logic       valid_q, valid_d;
   logic [3:0] nactive;

   assign nactive = {nch4_active, nch3_active, nch2_active, nch1_active};
   assign phase_d = phase_q + 3'd1;
   assign valid_d = (phase_q == 3'd7);

   always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
      if (!napu_reset) begin
         phase_q <= 3'd0;
         valid_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         valid_q <= valid_d;
      end
   end

   apu_mixer_side #(.SAMPLE_W(SAMPLE_W), .VIN_EN(VIN_EN)) u_left (
      .clk_i     (apuv_4mhz),
      .rst_ni    (napu_reset),
      .phase_i   (phase_q),
      .ch1_i     (ch1_out),
      .ch2_i     (ch2_out),
      .ch3_i     (ch3_out),
      .ch4_i     (ch4_out),
      .nactive_i (nactive),
      .mixer_i   (lmixer),
      .nvolume_i (nlvolume),
      .vin_ena_i (vin_l_ena),
      .vin_i     (vin_in),
      .out_o     (lout)
   );

   apu_mixer_side #(.SAMPLE_W(SAMPLE_W), .VIN_EN(VIN_EN)) u_right (
      .clk_i     (apuv_4mhz),
      .rst_ni    (napu_reset),
      .phase_i   (phase_q),
      .ch1_i     (ch1_out),
      .ch2_i     (ch2_out),
      .ch3_i     (ch3_out),
      .ch4_i     (ch4_out),
      .nactive_i (nactive),
      .mixer_i   (rmixer),
      .nvolume_i (nrvolume),
      .vin_ena_i (vin_r_ena),
      .vin_i     (vin_in),
      .out_o     (rout)
   );

   assign sample_valid = valid_q;
   assign phase        = phase_q;
endmodule

// File: tb/tb_apu_mixer_seq.sv
// Scoreboarded bench for apu_mixer_seq: VIN-enabled and VIN-disabled builds side by side,
// expected stereo words queued per frame and popped on each sample_valid strobe.

module tb_apu_mixer_seq;
   localparam int SW = 4;
   localparam int OW = SW + 6;

   logic          clk = 1'b0;
   logic          napu_reset;
   logic [SW-1:0] ch1, ch2, ch3, ch4, vin;
   logic          nch1, nch2, nch3, nch4;
   logic [3:0]    lmixer, rmixer;
   logic [2:0]    nlvol, nrvol;
   logic          vin_l, vin_r;

   logic [OW-1:0] lout1, rout1, lout0, rout0;
   logic          sv1, sv0;
   logic [2:0]    ph1, ph0;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   logic [2*OW-1:0] q1[$];
   logic [2*OW-1:0] q0[$];

   always #5 clk = ~clk;

   apu_mixer_seq #(.SAMPLE_W(SW), .VIN_EN(1'b1)) dut_vin (
      .apuv_4mhz(clk), .napu_reset(napu_reset),
      .ch1_out(ch1), .ch2_out(ch2), .ch3_out(ch3), .ch4_out(ch4),
      .nch1_active(nch1), .nch2_active(nch2), .nch3_active(nch3), .nch4_active(nch4),
      .lmixer(lmixer), .rmixer(rmixer), .nlvolume(nlvol), .nrvolume(nrvol),
      .vin_l_ena(vin_l), .vin_r_ena(vin_r), .vin_in(vin),
      .lout(lout1), .rout(rout1), .sample_valid(sv1), .phase(ph1)
   );

   apu_mixer_seq #(.SAMPLE_W(SW), .VIN_EN(1'b0)) dut_novin (
      .apuv_4mhz(clk), .napu_reset(napu_reset),
      .ch1_out(ch1), .ch2_out(ch2), .ch3_out(ch3), .ch4_out(ch4),
      .nch1_active(nch1), .nch2_active(nch2), .nch3_active(nch3), .nch4_active(nch4),
      .lmixer(lmixer), .rmixer(rmixer), .nlvolume(nlvol), .nrvolume(nrvol),
      .vin_l_ena(vin_l), .vin_r_ena(vin_r), .vin_in(vin),
      .lout(lout0), .rout(rout0), .sample_valid(sv0), .phase(ph0)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      ch1 = '0; ch2 = '0; ch3 = '0; ch4 = '0; vin = '0;
      nch1 = 1'b1; nch2 = 1'b1; nch3 = 1'b1; nch4 = 1'b1;
      lmixer = 4'h0; rmixer = 4'h0;
      nlvol = 3'b111; nrvol = 3'b111;
      vin_l = 1'b0; vin_r = 1'b0;
   endtask

   task automatic push_exp(input int l1, input int r1, input int l0, input int r0);
      q1.push_back({OW'(l1), OW'(r1)});
      q0.push_back({OW'(l0), OW'(r0)});
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int l1, input int r1, input int l0, input int r0);
      push_exp(l1, r1, l0, r0);
      wait_edges(8);
   endtask

   task automatic full_mix_setup();
      idle();
      ch1 = 4'd15; ch2 = 4'd15; ch3 = 4'd15; ch4 = 4'd15; vin = 4'd15;
      nch1 = 1'b0; nch2 = 1'b0; nch3 = 1'b0; nch4 = 1'b0;
      lmixer = 4'hF; rmixer = 4'hF;
      vin_l = 1'b1; vin_r = 1'b0;
      nlvol = 3'b000; nrvol = 3'b101;
   endtask

   // Bench-side frame counter: strobe and phase are predicted from cycles since reset release.
   always @(posedge clk or negedge napu_reset) begin
      if (!napu_reset) cyc <= 0;
      else             cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      logic [2*OW-1:0] e;
      chk("strobe_vin",   int'(sv1), int'(cyc != 0 && cyc % 8 == 0));
      chk("strobe_novin", int'(sv0), int'(cyc != 0 && cyc % 8 == 0));
      chk("phase",        int'(ph1), cyc % 8);
      if (sv1) begin
         if (q1.size() == 0) chk("unexpected_strobe_vin", 1, 0);
         else begin
            e = q1.pop_front();
            chk("lout_vin", int'(lout1), int'(e[2*OW-1:OW]));
            chk("rout_vin", int'(rout1), int'(e[OW-1:0]));
         end
      end
      if (sv0) begin
         if (q0.size() == 0) chk("unexpected_strobe_novin", 1, 0);
         else begin
            e = q0.pop_front();
            chk("lout_novin", int'(lout0), int'(e[2*OW-1:OW]));
            chk("rout_novin", int'(rout0), int'(e[OW-1:0]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int sweep_exp[8];
      sweep_exp = '{7, 14, 21, 28, 35, 42, 49, 56};

      napu_reset = 1'b0;
      idle();
      #12;
      chk("reset_lout", int'(lout1), 0);
      chk("reset_rout", int'(rout1), 0);
      chk("reset_valid", int'(sv1), 0);
      chk("reset_phase", int'(ph1), 0);

      // Single channel, left only, vol 0
      ch1 = 4'd15; nch1 = 1'b0; lmixer = 4'b0001;
      @(negedge clk);
      napu_reset = 1'b1;
      repeat (3) run_frame(15, 0, 15, 0);

      // Full mix: left 75*8, right 60*3; VIN-less build drops the left VIN term
      full_mix_setup();
      repeat (2) run_frame(600, 180, 480, 180);

      // Channel 2 inactive
      nch2 = 1'b1;
      run_frame(480, 135, 360, 135);

      // Volume sweep on ch3=7; right side fixed at vol 0
      idle();
      ch3 = 4'd7; nch3 = 1'b0; lmixer = 4'b0100; rmixer = 4'b0100;
      for (int v = 0; v < 8; v++) begin
         nlvol = ~3'(v);
         run_frame(sweep_exp[v], 7, sweep_exp[v], 7);
      end

      // Mixer cleared mid-frame after ch1 was already consumed
      idle();
      ch1 = 4'd9; nch1 = 1'b0; lmixer = 4'h1;
      push_exp(9, 0, 9, 0);
      wait_edges(2);
      lmixer = 4'h0;
      wait_edges(6);
      run_frame(0, 0, 0, 0);

      // Reset at phase 4 with a partial sum in flight
      full_mix_setup();
      wait_edges(4);
      #2;
      napu_reset = 1'b0;
      #1;
      chk("midreset_lout", int'(lout1), 0);
      chk("midreset_rout", int'(rout1), 0);
      chk("midreset_valid", int'(sv1), 0);
      chk("midreset_phase", int'(ph1), 0);
      chk("midreset_lout_novin", int'(lout0), 0);
      repeat (2) @(negedge clk);
      napu_reset = 1'b1;
      run_frame(600, 180, 480, 180);

      @(negedge clk);
      #1;
      chk("queue_drained_vin", q1.size(), 0);
      chk("queue_drained_novin", q0.size(), 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
